// File: rtl/pid_pwm_driver.sv
// pid_pwm_driver: complementary gate drive with dead time,
// double-buffered slew-limited duty and latched fault shutdown.
module pid_pwm_driver #(
    parameter int PRESCALE  = 4,
    parameter int DEAD_TIME = 2,
    parameter int MAX_STEP  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] duty_in,
    input  logic       duty_valid,
    input  logic       fault,
    output logic       pwm_hi,
    output logic       pwm_lo,
    output logic       period_start,
    output logic [7:0] duty_applied,
    output logic       faulted
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DW = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);
    localparam logic [DW-1:0] DT_LAST = DW'(DEAD_TIME - 1);
    localparam logic [8:0] STEP  = 9'(MAX_STEP);
    localparam logic [7:0] STEP8 = 8'(MAX_STEP);

    typedef enum logic [2:0] {
        IDLE,
        DEAD,
        DRV_HI,
        DRV_LO,
        FAULT
    } state_t;

    state_t        state;
    logic          target;
    logic [DW-1:0] dead_cnt;
    logic [PW-1:0] presc;
    logic [7:0]    cnt;
    logic [7:0]    pending;
    logic          pend_flag;
    logic          running;
    logic          tick;
    logic          wrap;
    logic          raw;
    logic          going_idle;
    logic [8:0]    up_d;
    logic [8:0]    dn_d;
    logic [7:0]    slewed;
    logic          slew_done;

    assign running    = enable & ~fault &
                        (state inside {DEAD, DRV_HI, DRV_LO});
    assign tick       = (presc == PS_LAST);
    assign wrap       = running & tick & (cnt == 8'd254);
    assign raw        = (cnt < duty_applied);
    assign going_idle = ~fault & ~enable;
    assign up_d       = {1'b0, pending} - {1'b0, duty_applied};
    assign dn_d       = {1'b0, duty_applied} - {1'b0, pending};

    // Next applied duty: jump to pending when close, else step by MAX_STEP
    always_comb begin
        slewed    = pending;
        slew_done = 1'b1;
        if (pending > duty_applied) begin
            if (up_d > STEP) begin
                slewed    = duty_applied + STEP8;
                slew_done = 1'b0;
            end
        end else if (dn_d > STEP) begin
            slewed    = duty_applied - STEP8;
            slew_done = 1'b0;
        end
    end

    // Prescaler and period counter run only while the gate FSM is active
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc        <= '0;
            cnt          <= 8'd0;
            period_start <= 1'b0;
        end else begin
            period_start <= wrap;
            if (!running) begin
                presc <= '0;
                cnt   <= 8'd0;
            end else if (tick) begin
                presc <= '0;
                cnt   <= (cnt == 8'd254) ? 8'd0 : cnt + 8'd1;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    // Pending capture; applied duty only moves at period wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending      <= 8'd0;
            pend_flag    <= 1'b0;
            duty_applied <= 8'd0;
        end else begin
            if (going_idle) begin
                duty_applied <= 8'd0;
                pend_flag    <= 1'b0;
            end else if (wrap && pend_flag) begin
                duty_applied <= slewed;
                if (slew_done) begin
                    pend_flag <= 1'b0;
                end
            end
            if (duty_valid) begin
                pending   <= duty_in;
                pend_flag <= 1'b1;
            end
        end
    end

    // Gate-drive FSM; gates are registered from the chosen next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            target   <= 1'b0;
            dead_cnt <= '0;
            pwm_hi   <= 1'b0;
            pwm_lo   <= 1'b0;
            faulted  <= 1'b0;
        end else if (fault) begin
            state    <= FAULT;
            target   <= 1'b0;
            dead_cnt <= '0;
            pwm_hi   <= 1'b0;
            pwm_lo   <= 1'b0;
            faulted  <= 1'b1;
        end else if (state == FAULT) begin
            if (!enable) begin
                state   <= IDLE;
                faulted <= 1'b0;
            end
        end else if (!enable) begin
            state    <= IDLE;
            dead_cnt <= '0;
            pwm_hi   <= 1'b0;
            pwm_lo   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    state    <= DEAD;
                    target   <= raw;
                    dead_cnt <= '0;
                end
                DEAD: begin
                    if (raw != target) begin
                        target   <= raw;
                        dead_cnt <= '0;
                    end else if (dead_cnt == DT_LAST) begin
                        if (target) begin
                            state  <= DRV_HI;
                            pwm_hi <= 1'b1;
                        end else begin
                            state  <= DRV_LO;
                            pwm_lo <= 1'b1;
                        end
                    end else begin
                        dead_cnt <= dead_cnt + 1'b1;
                    end
                end
                DRV_HI: begin
                    if (!raw) begin
                        state    <= DEAD;
                        target   <= 1'b0;
                        dead_cnt <= '0;
                        pwm_hi   <= 1'b0;
                    end
                end
                DRV_LO: begin
                    if (raw) begin
                        state    <= DEAD;
                        target   <= 1'b1;
                        dead_cnt <= '0;
                        pwm_lo   <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    pwm_hi <= 1'b0;
                    pwm_lo <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pid_pwm_driver.sv
// tb_pid_pwm_driver: scoreboard bench with a period-level model
// of duty slewing, fault latching and gate on-times.
module tb_pid_pwm_driver;

    localparam int PS  = 4;
    localparam int DT  = 2;
    localparam int MS  = 16;
    localparam int PER = 255 * PS;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] duty_in = 8'd0;
    logic       duty_valid = 1'b0;
    logic       fault = 1'b0;
    logic       pwm_hi;
    logic       pwm_lo;
    logic       period_start;
    logic [7:0] duty_applied;
    logic       faulted;

    pid_pwm_driver #(
        .PRESCALE (PS),
        .DEAD_TIME(DT),
        .MAX_STEP (MS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .duty_in     (duty_in),
        .duty_valid  (duty_valid),
        .fault       (fault),
        .pwm_hi      (pwm_hi),
        .pwm_lo      (pwm_lo),
        .period_start(period_start),
        .duty_applied(duty_applied),
        .faulted     (faulted)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: run time in clocks, wrap every PER clocks
    typedef enum {M_IDLE, M_RUN, M_FAULT} mst_t;
    mst_t mst = M_IDLE;
    int   t = 0;
    int   m_app = 0;
    int   m_pend = 0;
    bit   m_flag = 1'b0;
    int   expq[$];

    initial begin
        int d;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mst = M_IDLE;
                t = 0;
                m_app = 0;
                m_pend = 0;
                m_flag = 1'b0;
                expq.delete();
            end else begin
                if (fault) begin
                    mst = M_FAULT;
                end else if (!enable) begin
                    mst = M_IDLE;
                    m_app = 0;
                    m_flag = 1'b0;
                end else if (mst == M_IDLE) begin
                    mst = M_RUN;
                    t = 0;
                end else if (mst == M_RUN) begin
                    t++;
                    if (t == PER) begin
                        t = 0;
                        if (m_flag) begin
                            d = m_pend - m_app;
                            if (d <= MS && d >= -MS) begin
                                m_app = m_pend;
                                m_flag = 1'b0;
                            end else begin
                                m_app += (d > 0) ? MS : -MS;
                            end
                        end
                        expq.push_back(m_app);
                    end
                end
                if (duty_valid) begin
                    m_pend = int'(duty_in);
                    m_flag = 1'b1;
                end
            end
        end
    end

    // Monitor: per-clock checks plus per-period gate on-time checks
    initial begin
        int  hi_n = 0;
        int  lo_n = 0;
        int  win_app = -1;
        int  prev_app = -1;
        bit  win_ok = 1'b0;
        bit  prev_hi = 1'b0;
        bit  prev_lo = 1'b0;
        int  lowrun = 0;
        int  a;
        int  p;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hi_n = 0;
                lo_n = 0;
                win_app = -1;
                prev_app = -1;
                win_ok = 1'b0;
                prev_hi = 1'b0;
                prev_lo = 1'b0;
                lowrun = 0;
                continue;
            end
            chk("duty_applied", int'(duty_applied), m_app);
            chk("faulted", int'(faulted), (mst == M_FAULT) ? 1 : 0);
            chk("gate_overlap", int'(pwm_hi & pwm_lo), 0);
            if (mst != M_RUN)
                chk("gates_off", int'({pwm_hi, pwm_lo}), 0);
            chk("period_start", int'(period_start),
                (expq.size() != 0) ? 1 : 0);
            if (expq.size() != 0) begin
                a = expq.pop_front();
                if (period_start)
                    chk("wrap_duty", int'(duty_applied), a);
            end
            if ((pwm_hi && !prev_hi) || (pwm_lo && !prev_lo))
                chk("dead_time", (lowrun < DT) ? lowrun : DT, DT);
            lowrun = (!pwm_hi && !pwm_lo) ? lowrun + 1 : 0;
            prev_hi = pwm_hi;
            prev_lo = pwm_lo;
            if (period_start) begin
                a = win_app;
                p = prev_app;
                if (win_ok) begin
                    if (a >= 1 && a <= 254 && p >= 1 && p <= 254) begin
                        chk("hi_time", hi_n, 4 * a - DT);
                        chk("lo_time", lo_n, PER - 4 * a - DT);
                    end else if (a == 0 && p == 0) begin
                        chk("hi_time_0", hi_n, 0);
                        chk("lo_time_0", lo_n, PER);
                    end else if (a == 255 && p == 255) begin
                        chk("hi_time_ff", hi_n, PER);
                        chk("lo_time_ff", lo_n, 0);
                    end
                end
                win_ok = (mst == M_RUN);
                prev_app = win_app;
                win_app = m_app;
                hi_n = 0;
                lo_n = 0;
            end else if (mst != M_RUN) begin
                win_ok = 1'b0;
                win_app = -1;
            end
            hi_n += int'(pwm_hi);
            lo_n += int'(pwm_lo);
        end
    end

    task automatic strobe(input logic [7:0] d);
        duty_in = d;
        duty_valid = 1'b1;
        @(negedge clk);
        duty_valid = 1'b0;
    endtask

    task automatic wait_ps();
        int k = 0;
        @(negedge clk);
        while (!period_start && k < PER + 8) begin
            @(negedge clk);
            k++;
        end
        if (!period_start)
            chk("period_timeout", int'(period_start), 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_hi"}, int'(pwm_hi), 0);
        chk({tag, "_lo"}, int'(pwm_lo), 0);
        chk({tag, "_ps"}, int'(period_start), 0);
        chk({tag, "_duty"}, int'(duty_applied), 0);
        chk({tag, "_flt"}, int'(faulted), 0);
    endtask

    initial begin
        int k;
        logic [7:0] d;

        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        enable = 1'b1;
        @(negedge clk);
        strobe(8'h80);
        repeat (11) wait_ps();

        strobe(8'h40);
        repeat (100) @(negedge clk);
        strobe(8'h20);
        repeat (8) wait_ps();

        wait_ps();
        repeat (PER - 1) @(negedge clk);
        strobe(8'h60);
        chk("wrap_strobe_hold", int'(duty_applied), 8'h20);
        repeat (4) wait_ps();

        strobe(8'h00);
        repeat (8) wait_ps();
        chk("duty_zero", int'(duty_applied), 0);

        strobe(8'hFF);
        repeat (19) wait_ps();
        chk("duty_full", int'(duty_applied), 255);

        k = 0;
        while (!pwm_hi && k < 2 * PER) begin
            @(negedge clk);
            k++;
        end
        chk("hi_before_fault", int'(pwm_hi), 1);
        fault = 1'b1;
        @(negedge clk);
        chk("fault_gates", int'({pwm_hi, pwm_lo}), 0);
        chk("fault_flag", int'(faulted), 1);
        repeat (3) @(negedge clk);
        fault = 1'b0;
        repeat (6) @(negedge clk);
        chk("fault_latched", int'(faulted), 1);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("fault_cleared", int'(faulted), 0);
        enable = 1'b1;
        repeat (2) @(negedge clk);
        strobe(8'h50);
        repeat (7) wait_ps();

        for (int i = 0; i < 5; i++) begin
            d = 8'($urandom_range(0, 255));
            repeat ($urandom_range(1, 600)) @(negedge clk);
            strobe(d);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 900)) @(negedge clk);
                strobe(8'($urandom_range(0, 255)));
            end
            repeat ($urandom_range(1, 2)) wait_ps();
        end

        repeat (300) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_zero("mid_reset");
        enable = 1'b0;
        duty_valid = 1'b0;
        fault = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_reset_duty", int'(duty_applied), 0);
        enable = 1'b1;
        repeat (2) wait_ps();

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
